// File: rtl/gate_response_checker.sv
// Response checker for a single-output reduction gate: compares each accepted sample against the
// golden function, tracks input-space coverage and errors, and holds a PASS/FAIL verdict.
module gate_response_checker #(
  parameter int N_IN      = 2,
  parameter int GATE_OP   = 0,
  parameter int ERR_CNT_W = 8,
  parameter int VEC_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 sample_valid,
  input  logic [N_IN-1:0]      in_vec,
  input  logic                 dut_out,
  output logic                 expected,
  output logic                 mismatch,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [VEC_CNT_W-1:0] vec_count,
  output logic [(1<<N_IN)-1:0] coverage,
  output logic [N_IN-1:0]      first_err_vec,
  output logic                 pass,
  output logic                 fail
);
  localparam int NV = 1 << N_IN;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_PASS, S_FAIL} state_t;

  state_t                 state_q, state_d;
  logic                   expected_q, expected_d;
  logic                   mismatch_q, mismatch_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d;
  logic [VEC_CNT_W-1:0]   vec_q, vec_d;
  logic [NV-1:0]          cov_q, cov_d;
  logic [N_IN-1:0]        first_q, first_d;

  logic          golden, mis;
  logic [NV-1:0] cov_hit;

  always_comb begin
    case (GATE_OP)
      0:       golden = &in_vec;
      1:       golden = |in_vec;
      2:       golden = ^in_vec;
      3:       golden = ~&in_vec;
      4:       golden = ~|in_vec;
      default: golden = ~^in_vec;
    endcase
    cov_hit         = '0;
    cov_hit[in_vec] = 1'b1;
  end

  assign mis = dut_out ^ golden;

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    vec_d      = vec_q;
    cov_d      = cov_q;
    first_d    = first_q;
    // clear outranks a same-cycle sample, which is dropped entirely
    if (clear) begin
      state_d    = S_IDLE;
      expected_d = 1'b0;
      err_d      = '0;
      vec_d      = '0;
      cov_d      = '0;
      first_d    = '0;
    end else if (sample_valid) begin
      expected_d = golden;
      mismatch_d = mis;
      cov_d      = cov_q | cov_hit;
      if (vec_q != '1) vec_d = vec_q + VEC_CNT_W'(1);
      if (mis) begin
        if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
        if (err_q == '0) first_d = in_vec;
      end
      case (state_q)
        S_IDLE, S_CHECK: begin
          if (mis)         state_d = S_FAIL;
          else if (&cov_d) state_d = S_PASS;
          else             state_d = S_CHECK;
        end
        S_PASS:  if (mis) state_d = S_FAIL;
        default: state_d = S_FAIL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      expected_q <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
      vec_q      <= '0;
      cov_q      <= '0;
      first_q    <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      vec_q      <= vec_d;
      cov_q      <= cov_d;
      first_q    <= first_d;
    end
  end

  assign expected      = expected_q;
  assign mismatch      = mismatch_q;
  assign err_count     = err_q;
  assign vec_count     = vec_q;
  assign coverage      = cov_q;
  assign first_err_vec = first_q;
  assign pass          = (state_q == S_PASS);
  assign fail          = (state_q == S_FAIL);
endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker (N_IN=2, AND): directed scenarios plus randomized traffic,
// all checked against a counting model of the checker's observable behaviour.
module tb_gate_response_checker;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       sample_valid = 1'b0;
  logic [1:0] in_vec = '0;
  logic       dut_out = 1'b0;
  logic       expected, mismatch, pass, fail;
  logic [7:0] err_count;
  logic [15:0] vec_count;
  logic [3:0] coverage;
  logic [1:0] first_err_vec;

  int n_chk = 0;
  int n_fail = 0;

  // model state: plain counts and flags since the last clear/reset
  logic m_exp, m_mis;
  int   m_errs, m_vecs;
  bit   m_seen [4];
  logic [1:0] m_first;

  gate_response_checker #(.N_IN(2), .GATE_OP(0), .ERR_CNT_W(8), .VEC_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .sample_valid(sample_valid), .in_vec(in_vec),
    .dut_out(dut_out), .expected(expected), .mismatch(mismatch), .err_count(err_count),
    .vec_count(vec_count), .coverage(coverage), .first_err_vec(first_err_vec),
    .pass(pass), .fail(fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic gold(input logic [1:0] v);
    int ones = 0;
    for (int i = 0; i < 2; i++) ones += v[i];
    return (ones == 2);
  endfunction

  task automatic m_reset();
    m_exp = 0; m_mis = 0; m_errs = 0; m_vecs = 0; m_first = '0;
    for (int k = 0; k < 4; k++) m_seen[k] = 0;
  endtask

  function automatic logic [3:0] m_cov();
    logic [3:0] c;
    for (int k = 0; k < 4; k++) c[k] = m_seen[k];
    return c;
  endfunction

  task automatic check_all(input string tag);
    logic all_cov;
    all_cov = &m_cov();
    chk({tag, ".expected"}, 32'(expected), 32'(m_exp));
    chk({tag, ".mismatch"}, 32'(mismatch), 32'(m_mis));
    chk({tag, ".err_count"}, 32'(err_count), (m_errs > 255) ? 32'd255 : 32'(m_errs));
    chk({tag, ".vec_count"}, 32'(vec_count), (m_vecs > 65535) ? 32'd65535 : 32'(m_vecs));
    chk({tag, ".coverage"}, 32'(coverage), 32'(m_cov()));
    chk({tag, ".first_err_vec"}, 32'(first_err_vec), 32'(m_first));
    chk({tag, ".fail"}, 32'(fail), 32'(m_errs > 0));
    chk({tag, ".pass"}, 32'(pass), 32'(m_errs == 0 && all_cov));
  endtask

  task automatic step(input string tag, input logic c, input logic v,
                      input logic [1:0] vec, input logic o);
    logic g;
    @(negedge clk);
    clear = c; sample_valid = v; in_vec = vec; dut_out = o;
    @(posedge clk);
    if (c) m_reset();
    else if (v) begin
      g = gold(vec);
      m_exp = g;
      m_mis = (o != g);
      m_vecs++;
      m_seen[vec] = 1;
      if (m_mis) begin
        if (m_errs == 0) m_first = vec;
        m_errs++;
      end
    end else m_mis = 0;
    #1 check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic do_clear();
    step("clr", 1'b1, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic run_t1(input string tag);
    for (int i = 0; i < 4; i++) step(tag, 1'b0, 1'b1, 2'(i), (i == 3));
    chk({tag, ".pass_lit"}, 32'(pass), 32'd1);
    chk({tag, ".cov_lit"}, 32'(coverage), 32'hF);
    chk({tag, ".vec_lit"}, 32'(vec_count), 32'd4);
  endtask

  initial begin
    m_reset();
    #2 check_all("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle("post_reset");

    // 1: full coverage, all correct
    run_t1("t1");
    idle("t1_hold");

    // 2: failing final vector, then a correct repeat
    do_clear();
    for (int i = 0; i < 3; i++) step("t2", 1'b0, 1'b1, 2'(i), 1'b0);
    step("t2_bad", 1'b0, 1'b1, 2'b11, 1'b0);
    chk("t2.mismatch_lit", 32'(mismatch), 32'd1);
    chk("t2.first_lit", 32'(first_err_vec), 32'd3);
    chk("t2.fail_lit", 32'(fail), 32'd1);
    step("t2_fix", 1'b0, 1'b1, 2'b11, 1'b1);
    chk("t2.mismatch_drop", 32'(mismatch), 32'd0);
    chk("t2.err_lit", 32'(err_count), 32'd1);

    // 3: partial coverage with repeats
    do_clear();
    step("t3", 1'b0, 1'b1, 2'd0, 1'b0);
    step("t3", 1'b0, 1'b1, 2'd1, 1'b0);
    step("t3", 1'b0, 1'b1, 2'd1, 1'b0);
    step("t3", 1'b0, 1'b1, 2'd0, 1'b0);
    step("t3", 1'b0, 1'b1, 2'd2, 1'b0);
    chk("t3.cov_lit", 32'(coverage), 32'h7);
    chk("t3.pass_lit", 32'(pass), 32'd0);

    // 4: error counter saturation
    do_clear();
    for (int i = 0; i < 300; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(0, 3));
      step("t4", 1'b0, 1'b1, v, ~gold(v));
    end
    chk("t4.err_sat", 32'(err_count), 32'd255);
    chk("t4.vec_lit", 32'(vec_count), 32'd300);

    // 5: clear beats a same-cycle sample
    do_clear();
    run_t1("t5_pre");
    step("t5_clr", 1'b1, 1'b1, 2'b11, 1'b0);
    chk("t5.vec_lit", 32'(vec_count), 32'd0);
    chk("t5.pass_lit", 32'(pass), 32'd0);

    // 6: async reset mid-cycle, then a clean rerun
    step("t6", 1'b0, 1'b1, 2'd0, 1'b0);
    step("t6", 1'b0, 1'b1, 2'd3, 1'b1);
    @(negedge clk);
    sample_valid = 1'b0;
    #2 rst = 1'b1;
    m_reset();
    #1 check_all("t6_async");
    @(negedge clk);
    rst = 1'b0;
    run_t1("t6_rerun");

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] v;
      logic c, sv, o;
      v  = 2'($urandom_range(0, 3));
      c  = ($urandom_range(0, 99) < 3);
      sv = ($urandom_range(0, 99) < 75);
      o  = gold(v) ^ ($urandom_range(0, 99) < 4);
      step("rand", c, sv, v, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
